// File: rtl/wavelet_output_pkg.sv
// ----------------------------------------------------------------------------
// wavelet_output_pkg
// Shared encodings for the wavelet output channel sequencer.
//   state_t : sequencer FSM states (ST_IDLE, ST_EMIT)
//   mode_t  : channel selection mode (MODE_STATIC, MODE_SCAN)
// ----------------------------------------------------------------------------
package wavelet_output_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    typedef enum logic {
        MODE_STATIC = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_t;

endpackage

// File: rtl/channel_priority_finder.sv
// ----------------------------------------------------------------------------
// channel_priority_finder
// Finds the lowest set bit of a channel mask at an index above a base
// pointer (or at/above it when i_inclusive is set).
// Ports:
//   i_mask      - channel enable mask
//   i_base      - search starts relative to this channel index
//   i_inclusive - 1: base itself is a candidate; 0: strictly above base
//   o_index     - lowest qualifying channel (0 when none)
//   o_none      - no qualifying channel exists
// ----------------------------------------------------------------------------
module channel_priority_finder #(
    parameter int NUM_FILTERS = 8,
    parameter int SEL_WIDTH   = 3
) (
    input  logic [NUM_FILTERS-1:0] i_mask,
    input  logic [SEL_WIDTH-1:0]   i_base,
    input  logic                   i_inclusive,
    output logic [SEL_WIDTH-1:0]   o_index,
    output logic                   o_none
);

    // Walk from the top down so the last hit written is the lowest index.
    always_comb begin
        // NOTE: every output gets a default before the loop, otherwise a
        // path that never hits would hold the old value and infer a latch.
        o_index = '0;
        o_none  = 1'b1;
        for (int k = NUM_FILTERS - 1; k >= 0; k--) begin
            if (i_mask[k] && ((k > int'(i_base)) || (i_inclusive && (k == int'(i_base))))) begin
                o_index = SEL_WIDTH'(k);
                o_none  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/output_channel_sequencer.sv
// ----------------------------------------------------------------------------
// output_channel_sequencer
// Serialises one filter-bank sample set into a stream of channel words with
// a valid/ready handshake. Static mode emits one selected channel; scan mode
// emits every channel enabled in the captured mask, lowest index first.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   i_truncated_wavelet_out   - all channel words, channel k at [k*W +: W]
//   i_sample_valid            - new sample set present this cycle
//   i_mode                    - 0 static, 1 scan
//   i_select_output_channel   - channel used in static mode
//   i_channel_mask            - channels enabled in scan mode
//   i_ready                   - downstream accepts the current word
//   o_multiplexed_wavelet_out - current word
//   o_valid                   - current word is valid
//   o_frame_start             - current word is the first of its frame
//   o_overrun                 - sticky: a sample set was dropped
//   o_channel                 - index of current word (only with
//                               OUTPUT_SEQ_CHANNEL_TAG_EN defined)
// ----------------------------------------------------------------------------
module output_channel_sequencer
    import wavelet_output_pkg::*;
#(
    parameter int NUM_FILTERS    = 8,
    parameter int SUM_TRUNCATION = 8,
    parameter int SEL_WIDTH      = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_FILTERS*SUM_TRUNCATION-1:0] i_truncated_wavelet_out,
    input  logic                                  i_sample_valid,
    input  logic                                  i_mode,
    input  logic [SEL_WIDTH-1:0]                  i_select_output_channel,
    input  logic [NUM_FILTERS-1:0]                i_channel_mask,
    input  logic                                  i_ready,
`ifdef OUTPUT_SEQ_CHANNEL_TAG_EN
    output logic [SEL_WIDTH-1:0]                  o_channel,
`endif
    output logic [SUM_TRUNCATION-1:0]             o_multiplexed_wavelet_out,
    output logic                                  o_valid,
    output logic                                  o_frame_start,
    output logic                                  o_overrun
);

    state_t                              r_state;
    state_t                              w_state_next;
    logic [NUM_FILTERS*SUM_TRUNCATION-1:0] r_snapshot;
    mode_t                               r_snap_mode;
    logic [NUM_FILTERS-1:0]              r_snap_mask;
    logic [SEL_WIDTH-1:0]                r_pointer;
    logic [SUM_TRUNCATION-1:0]           r_data;
    logic                                r_frame_start;
    logic                                r_overrun;
`ifdef OUTPUT_SEQ_CHANNEL_TAG_EN
    logic [SEL_WIDTH-1:0]                r_channel;
`endif

    logic                                w_capture;
    logic                                w_advance;
    logic                                w_final_hs;
    logic                                w_overrun_set;
    logic [SEL_WIDTH-1:0]                w_static_ch;
    logic [SEL_WIDTH-1:0]                w_scan_first_ch;
    logic                                w_scan_none;
    logic [SEL_WIDTH-1:0]                w_cap_ch;
    logic                                w_cap_empty;
    logic [SUM_TRUNCATION-1:0]           w_cap_word;
    logic [SEL_WIDTH-1:0]                w_next_ch;
    logic                                w_next_none;
    logic [SUM_TRUNCATION-1:0]           w_next_word;

    // First enabled channel of the live mask, used when capturing.
    channel_priority_finder #(.NUM_FILTERS(NUM_FILTERS), .SEL_WIDTH(SEL_WIDTH)) u_first_finder (
        .i_mask      (i_channel_mask),
        .i_base      ('0),
        .i_inclusive (1'b1),
        .o_index     (w_scan_first_ch),
        .o_none      (w_scan_none)
    );

    // Next enabled channel above the one being presented, from the snapshot.
    channel_priority_finder #(.NUM_FILTERS(NUM_FILTERS), .SEL_WIDTH(SEL_WIDTH)) u_next_finder (
        .i_mask      (r_snap_mask),
        .i_base      (r_pointer),
        .i_inclusive (1'b0),
        .o_index     (w_next_ch),
        .o_none      (w_next_none)
    );

    // Out-of-range static selects fall back to channel 0.
    assign w_static_ch = (int'(i_select_output_channel) >= NUM_FILTERS) ? '0 : i_select_output_channel;
    assign w_cap_ch    = (i_mode == MODE_SCAN) ? w_scan_first_ch : w_static_ch;
    assign w_cap_empty = (i_mode == MODE_SCAN) && w_scan_none;
    assign w_cap_word  = i_truncated_wavelet_out[int'(w_cap_ch)*SUM_TRUNCATION +: SUM_TRUNCATION];
    assign w_next_word = r_snapshot[int'(w_next_ch)*SUM_TRUNCATION +: SUM_TRUNCATION];

    always_comb begin
        w_state_next  = r_state;
        w_capture     = 1'b0;
        w_advance     = 1'b0;
        w_final_hs    = 1'b0;
        w_overrun_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_sample_valid) begin
                    w_capture = 1'b1;
                    if (!w_cap_empty) w_state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (i_ready) begin
                    if ((r_snap_mode == MODE_SCAN) && !w_next_none) begin
                        w_advance = 1'b1;
                    end else begin
                        // Last word accepted: a coincident sample set starts
                        // the next frame back-to-back instead of overrunning.
                        w_final_hs   = 1'b1;
                        w_state_next = ST_IDLE;
                        if (i_sample_valid) begin
                            w_capture = 1'b1;
                            if (!w_cap_empty) w_state_next = ST_EMIT;
                        end
                    end
                end
                if (i_sample_valid && !w_final_hs) w_overrun_set = 1'b1;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the snapshot is a plain register bank, not a RAM, so it is
            // cleared with everything else to leave no stale frame behind.
            r_snapshot    <= '0;
            r_snap_mode   <= MODE_STATIC;
            r_snap_mask   <= '0;
            r_pointer     <= '0;
            r_data        <= '0;
            r_frame_start <= 1'b0;
            r_overrun     <= 1'b0;
`ifdef OUTPUT_SEQ_CHANNEL_TAG_EN
            r_channel     <= '0;
`endif
        end else begin
            if (w_capture) begin
                r_snapshot    <= i_truncated_wavelet_out;
                r_snap_mode   <= mode_t'(i_mode);
                r_snap_mask   <= i_channel_mask;
                r_data        <= w_cap_word;
                r_pointer     <= w_cap_ch;
                r_frame_start <= !w_cap_empty;
`ifdef OUTPUT_SEQ_CHANNEL_TAG_EN
                r_channel     <= w_cap_ch;
`endif
            end else if (w_advance) begin
                r_data        <= w_next_word;
                r_pointer     <= w_next_ch;
                r_frame_start <= 1'b0;
`ifdef OUTPUT_SEQ_CHANNEL_TAG_EN
                r_channel     <= w_next_ch;
`endif
            end else if (w_final_hs) begin
                r_frame_start <= 1'b0;
            end
            if (w_overrun_set) r_overrun <= 1'b1;
        end
    end

    assign o_valid                   = (r_state == ST_EMIT);
    assign o_multiplexed_wavelet_out = r_data;
    assign o_frame_start             = r_frame_start;
    assign o_overrun                 = r_overrun;
`ifdef OUTPUT_SEQ_CHANNEL_TAG_EN
    assign o_channel                 = r_channel;
`endif

endmodule

// File: tb/tb_output_channel_sequencer.sv
// ----------------------------------------------------------------------------
// tb_output_channel_sequencer
// Directed and randomised checks of output_channel_sequencer against a
// queue-based reference: each captured sample set expands into the list of
// words it must produce, consumed one entry per handshake.
// A second instance with NUM_FILTERS=6 covers the out-of-range select.
// ----------------------------------------------------------------------------
module tb_output_channel_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] bus;
    logic        sv;
    logic        mode;
    logic [2:0]  sel;
    logic [7:0]  mask;
    logic        ready;
    logic [7:0]  o_word;
    logic        o_valid, o_fs, o_ovr;
    logic [2:0]  o_ch;

    logic [47:0] bus6;
    logic        sv6;
    logic [7:0]  o_word6;
    logic        o_valid6, o_fs6, o_ovr6;
    logic [2:0]  o_ch6;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: expected words in emission order.
    logic [7:0] q_word[$];
    logic [2:0] q_ch[$];
    bit         q_fs[$];
    bit         exp_ovr;

    always #5 clk = ~clk;

    output_channel_sequencer dut (
        .clk                       (clk),
        .rst                       (rst),
        .i_truncated_wavelet_out   (bus),
        .i_sample_valid            (sv),
        .i_mode                    (mode),
        .i_select_output_channel   (sel),
        .i_channel_mask            (mask),
        .i_ready                   (ready),
`ifdef OUTPUT_SEQ_CHANNEL_TAG_EN
        .o_channel                 (o_ch),
`endif
        .o_multiplexed_wavelet_out (o_word),
        .o_valid                   (o_valid),
        .o_frame_start             (o_fs),
        .o_overrun                 (o_ovr)
    );

    output_channel_sequencer #(.NUM_FILTERS(6), .SUM_TRUNCATION(8), .SEL_WIDTH(3)) dut6 (
        .clk                       (clk),
        .rst                       (rst),
        .i_truncated_wavelet_out   (bus6),
        .i_sample_valid            (sv6),
        .i_mode                    (mode),
        .i_select_output_channel   (sel),
        .i_channel_mask            (mask[5:0]),
        .i_ready                   (ready),
`ifdef OUTPUT_SEQ_CHANNEL_TAG_EN
        .o_channel                 (o_ch6),
`endif
        .o_multiplexed_wavelet_out (o_word6),
        .o_valid                   (o_valid6),
        .o_frame_start             (o_fs6),
        .o_overrun                 (o_ovr6)
    );

`ifndef OUTPUT_SEQ_CHANNEL_TAG_EN
    assign o_ch  = '0;
    assign o_ch6 = '0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ramp_bus();
        logic [63:0] b;
        for (int k = 0; k < 8; k++) b[k*8 +: 8] = 8'h10 + 8'(k);
        return b;
    endfunction

    // Expand one captured sample set into the words it must produce.
    task automatic model_frame(input logic [63:0] b, input logic m, input logic [2:0] s, input logic [7:0] mk);
        int  c;
        bit  first;
        if (m == 1'b0) begin
            c = (int'(s) >= 8) ? 0 : int'(s);
            q_word.push_back(b[c*8 +: 8]);
            q_ch.push_back(3'(c));
            q_fs.push_back(1'b1);
        end else begin
            first = 1'b1;
            for (int k = 0; k < 8; k++) begin
                if (mk[k]) begin
                    q_word.push_back(b[k*8 +: 8]);
                    q_ch.push_back(3'(k));
                    q_fs.push_back(first);
                    first = 1'b0;
                end
            end
        end
    endtask

    task automatic scramble_cfg();
        mode = 1'($urandom);
        sel  = 3'($urandom);
        mask = 8'($urandom);
        bus  = {$urandom, $urandom};
    endtask

    task automatic capture(input logic [63:0] b, input logic m, input logic [2:0] s, input logic [7:0] mk);
        bus = b; mode = m; sel = s; mask = mk; sv = 1'b1;
        tick();
        sv = 1'b0;
        model_frame(b, m, s, mk);
        scramble_cfg();
    endtask

    // Consume the expected queue. Optionally stall on word stall_idx, and
    // present a new sample set while word inject_idx is on the output.
    task automatic drain(input int inject_idx, input int stall_idx, input int stall_len,
                         input bit rand_ready, input logic [63:0] nb, input logic nm,
                         input logic [2:0] ns, input logic [7:0] nmk);
        int  served = 0;
        int  stall_left = stall_len;
        int  budget = 300;
        bit  r, inj, injected = 1'b0, was_last;
        while (q_word.size() > 0) begin
            if (budget == 0) begin
                check("drain_timeout", 32'(q_word.size()), 0);
                q_word.delete(); q_ch.delete(); q_fs.delete();
                break;
            end
            budget--;
            check("valid", o_valid, 1'b1);
            check("word", o_word, q_word[0]);
            check("frame_start", o_fs, q_fs[0]);
`ifdef OUTPUT_SEQ_CHANNEL_TAG_EN
            check("channel", o_ch, q_ch[0]);
`endif
            check("overrun", o_ovr, exp_ovr);
            if (served == stall_idx && stall_left > 0) begin
                r = 1'b0;
                stall_left--;
            end else begin
                r = rand_ready ? 1'($urandom) : 1'b1;
            end
            inj = (served == inject_idx) && !injected;
            if (inj) begin
                injected = 1'b1;
                bus = nb; mode = nm; sel = ns; mask = nmk; sv = 1'b1;
            end
            was_last = (q_word.size() == 1);
            ready = r;
            tick();
            sv = 1'b0;
            scramble_cfg();
            if (r) begin
                void'(q_word.pop_front()); void'(q_ch.pop_front()); void'(q_fs.pop_front());
                served++;
            end
            if (inj) begin
                if (r && was_last) model_frame(nb, nm, ns, nmk);
                else               exp_ovr = 1'b1;
            end
        end
        ready = 1'($urandom);
        check("idle_valid", o_valid, 1'b0);
        check("idle_overrun", o_ovr, exp_ovr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rb;
        logic [47:0] rb6;
        rb = ramp_bus();
        for (int k = 0; k < 6; k++) rb6[k*8 +: 8] = 8'h10 + 8'(k);
        exp_ovr = 1'b0;
        rst = 1'b1; sv = 1'b0; sv6 = 1'b0; bus6 = rb6; ready = 1'b0;
        bus = '0; mode = 1'b0; sel = '0; mask = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_valid", o_valid, 1'b0);
        check("rst_frame_start", o_fs, 1'b0);
        check("rst_overrun", o_ovr, 1'b0);
        check("rst_word", o_word, 8'h00);
        check("rst_channel", o_ch, 3'd0);

        // Static, select 5 -> single word 0x15
        ready = 1'b1;
        capture(rb, 1'b0, 3'd5, 8'h00);
        drain(-1, -1, 0, 1'b0, '0, 1'b0, '0, '0);

        // Scan 0xA5 -> 0x10, 0x12, 0x15, 0x17
        capture(rb, 1'b1, 3'd0, 8'hA5);
        drain(-1, -1, 0, 1'b0, '0, 1'b0, '0, '0);

        // Scan with empty mask -> nothing emitted
        capture(rb, 1'b1, 3'd0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            check("empty_mask_valid", o_valid, 1'b0);
            tick();
        end

        // Scan 0xA5 with a 3-cycle stall while 0x12 is presented
        capture(rb, 1'b1, 3'd0, 8'hA5);
        drain(-1, 1, 3, 1'b0, '0, 1'b0, '0, '0);

        // New sample set on the final handshake -> back-to-back, no overrun
        capture(rb, 1'b1, 3'd0, 8'hA5);
        drain(3, -1, 0, 1'b0, {$urandom, $urandom}, 1'b0, 3'd2, 8'h00);
        check("b2b_overrun", o_ovr, 1'b0);

        // New sample set during the 2nd word -> overrun, frame unchanged
        capture(rb, 1'b1, 3'd0, 8'hA5);
        drain(1, -1, 0, 1'b0, {$urandom, $urandom}, 1'b1, 3'd0, 8'hFF);
        check("overrun_sticky", o_ovr, 1'b1);

        // Randomised frames, ready back-pressure and injected sample sets
        for (int f = 0; f < 40; f++) begin
            logic [63:0] b;
            logic        m;
            logic [2:0]  s;
            logic [7:0]  mk;
            int          inj;
            b  = {$urandom, $urandom};
            m  = 1'($urandom);
            s  = 3'($urandom);
            mk = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            inj = int'($urandom_range(0, 5)) - 1;
            capture(b, m, s, mk);
            drain(inj, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b1,
                  {$urandom, $urandom}, 1'($urandom), 3'($urandom), 8'($urandom));
        end

        // Reset after the 2nd handshake abandons the frame and clears overrun
        ready = 1'b1;
        capture(rb, 1'b1, 3'd0, 8'hA5);
        check("pre_rst_word0", o_word, 8'h10);
        tick();
        check("pre_rst_word1", o_word, 8'h12);
        tick();
        check("pre_rst_word2", o_word, 8'h15);
        rst = 1'b1; sv = 1'b1;
        tick();
        rst = 1'b0; sv = 1'b0;
        q_word.delete(); q_ch.delete(); q_fs.delete();
        exp_ovr = 1'b0;
        check("post_rst_valid", o_valid, 1'b0);
        check("post_rst_overrun", o_ovr, 1'b0);
        check("post_rst_frame_start", o_fs, 1'b0);
        check("post_rst_word", o_word, 8'h00);
        check("post_rst_channel", o_ch, 3'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_quiet", o_valid, 1'b0);
        end

        // NUM_FILTERS=6, static select 7 -> channel 0 fallback
        mode = 1'b0; sel = 3'd7; ready = 1'b0; sv6 = 1'b1;
        tick();
        sv6 = 1'b0;
        check("nf6_valid", o_valid6, 1'b1);
        check("nf6_word", o_word6, 8'h10);
        check("nf6_frame_start", o_fs6, 1'b1);
`ifdef OUTPUT_SEQ_CHANNEL_TAG_EN
        check("nf6_channel", o_ch6, 3'd0);
`endif
        ready = 1'b1;
        tick();
        check("nf6_done", o_valid6, 1'b0);
        check("nf6_overrun", o_ovr6, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
